// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and defaults for the perceptron predictor
// Entry widths follow the package defaults; the table uses the same Theta.
package bp_pkg;

  localparam int PTableSizeDef = 1024;
  localparam int GHRLenDef     = 12;
  localparam int YoutWidthDef  = 16;
  localparam int ThetaDef      = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EVAL  = 2'd2,
    WRITE = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [$clog2(PTableSizeDef)-1:0] index;
    logic                             taken;
    logic [GHRLenDef-1:0]             ghr;
  } upd_entry_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// rtl/bp_upd_fifo.sv - synchronous FIFO for queued predictor updates
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module bp_upd_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PtrW-1:0]];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[PtrW-1:0]] = data_i;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bp_update_sched.sv
// rtl/bp_update_sched.sv - perceptron-table update scheduler and port arbiter
// BP_SCHED_STATS_EN builds the drop/train statistics counters.
module bp_update_sched
  import bp_pkg::*;
#(
  parameter int PTableSize  = PTableSizeDef,
  parameter int GHRLen      = GHRLenDef,
  parameter int YoutWidth   = YoutWidthDef,
  parameter int Theta       = ThetaDef,
  parameter int QueueDepth  = 4,
  parameter int StarveLimit = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          ex_br_valid_i,
  input  logic [31:0]                   ex_br_instr_addr_i,
  input  logic                          ex_br_taken_i,
  input  logic                          lookup_req_i,
  input  logic [$clog2(PTableSize)-1:0] lookup_index_i,
  output logic                          lookup_gnt_o,
  output logic [GHRLen-1:0]             ghr_o,
  output logic                          tbl_req_o,
  output logic                          tbl_we_o,
  output logic [$clog2(PTableSize)-1:0] tbl_index_o,
  output logic [GHRLen-1:0]             tbl_ghr_o,
  output logic                          tbl_taken_o,
  input  logic signed [YoutWidth-1:0]   tbl_yout_i,
  output logic [15:0]                   drop_cnt_o,
  output logic [15:0]                   train_cnt_o
);

  localparam int IdxW  = $clog2(PTableSize);
  localparam int WaitW = $clog2(StarveLimit + 1);

  sched_state_e     state_q, state_d;
  logic [GHRLen-1:0] ghr_q, ghr_d;
  logic [WaitW-1:0] wait_q, wait_d;
  upd_entry_t       push_entry, head_entry;
  logic             fifo_full, fifo_empty, pop;
  logic             port_busy, force_port, sched_issue, train;
  logic [YoutWidth-1:0] yout_abs;
  logic             unused_addr;

  assign unused_addr = ^{ex_br_instr_addr_i[31:IdxW+2], ex_br_instr_addr_i[1:0]};

  assign push_entry.index = ex_br_instr_addr_i[IdxW+1:2];
  assign push_entry.taken = ex_br_taken_i;
  assign push_entry.ghr   = ghr_q;

  bp_upd_fifo #(
    .Width ($bits(upd_entry_t)),
    .Depth (QueueDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ex_br_valid_i),
    .pop_i   (pop),
    .data_i  (push_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head_entry)
  );

  assign ghr_o = ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (ex_br_valid_i) begin
      ghr_d = {ghr_q[GHRLen-2:0], ex_br_taken_i};
    end
  end

  // The most negative sum has no positive twin, so its magnitude clamps.
  always_comb begin
    if (tbl_yout_i == {1'b1, {(YoutWidth-1){1'b0}}}) begin
      yout_abs = {1'b0, {(YoutWidth-1){1'b1}}};
    end else if (tbl_yout_i[YoutWidth-1]) begin
      yout_abs = -tbl_yout_i;
    end else begin
      yout_abs = tbl_yout_i;
    end
    train = (tbl_yout_i[YoutWidth-1] == head_entry.taken) ||
            (yout_abs < YoutWidth'(Theta));
  end

  // Nothing from the scheduler reaches the port in a reset cycle.
  always_comb begin
    port_busy    = (state_q == READ) || (state_q == WRITE);
    force_port   = port_busy && (wait_q == WaitW'(StarveLimit)) && !rst_i;
    lookup_gnt_o = lookup_req_i & ~force_port;
    sched_issue  = port_busy && !lookup_gnt_o && !rst_i;

    tbl_req_o   = 1'b0;
    tbl_we_o    = 1'b0;
    tbl_index_o = '0;
    tbl_ghr_o   = '0;
    tbl_taken_o = 1'b0;
    if (lookup_gnt_o) begin
      tbl_req_o   = 1'b1;
      tbl_index_o = lookup_index_i;
      tbl_ghr_o   = ghr_q;
    end else if (sched_issue) begin
      tbl_req_o   = 1'b1;
      tbl_we_o    = (state_q == WRITE);
      tbl_index_o = head_entry.index;
      tbl_ghr_o   = head_entry.ghr;
      tbl_taken_o = (state_q == WRITE) & head_entry.taken;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = READ;
      end
      READ: begin
        if (sched_issue) begin
          state_d = EVAL;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      EVAL: begin
        if (train) begin
          state_d = WRITE;
        end else begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (sched_issue) begin
          pop     = 1'b1;
          state_d = IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ghr_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ghr_q   <= ghr_d;
      wait_q  <= wait_d;
    end
  end

`ifdef BP_SCHED_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] train_cnt_q, train_cnt_d;
  logic        drop, train_done;

  assign drop       = ex_br_valid_i & fifo_full & ~pop;
  assign train_done = pop & (state_q == WRITE);

  always_comb begin
    drop_cnt_d  = drop_cnt_q;
    train_cnt_d = train_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    if (train_done && train_cnt_q != 16'hFFFF) train_cnt_d = train_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q  <= '0;
      train_cnt_q <= '0;
    end else begin
      drop_cnt_q  <= drop_cnt_d;
      train_cnt_q <= train_cnt_d;
    end
  end

  assign drop_cnt_o  = drop_cnt_q;
  assign train_cnt_o = train_cnt_q;
`else
  assign drop_cnt_o  = '0;
  assign train_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_update_sched.sv
// tb/tb_bp_update_sched.sv - directed bench for bp_update_sched
// Table of EVAL decisions plus hand sequences for starvation, overflow and reset.
module tb_bp_update_sched;

`ifdef BP_SCHED_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_i;
  logic               ex_br_valid_i;
  logic [31:0]        ex_br_instr_addr_i;
  logic               ex_br_taken_i;
  logic               lookup_req_i;
  logic [9:0]         lookup_index_i;
  logic               lookup_gnt_o;
  logic [11:0]        ghr_o;
  logic               tbl_req_o;
  logic               tbl_we_o;
  logic [9:0]         tbl_index_o;
  logic [11:0]        tbl_ghr_o;
  logic               tbl_taken_o;
  logic signed [15:0] tbl_yout_i;
  logic [15:0]        drop_cnt_o;
  logic [15:0]        train_cnt_o;

  bp_update_sched dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .ex_br_valid_i      (ex_br_valid_i),
    .ex_br_instr_addr_i (ex_br_instr_addr_i),
    .ex_br_taken_i      (ex_br_taken_i),
    .lookup_req_i       (lookup_req_i),
    .lookup_index_i     (lookup_index_i),
    .lookup_gnt_o       (lookup_gnt_o),
    .ghr_o              (ghr_o),
    .tbl_req_o          (tbl_req_o),
    .tbl_we_o           (tbl_we_o),
    .tbl_index_o        (tbl_index_o),
    .tbl_ghr_o          (tbl_ghr_o),
    .tbl_taken_o        (tbl_taken_o),
    .tbl_yout_i         (tbl_yout_i),
    .drop_cnt_o         (drop_cnt_o),
    .train_cnt_o        (train_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic               taken;
    logic signed [15:0] yout;
    logic [9:0]         idx;
    logic               exp_wr;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i              = 1'b1;
    ex_br_valid_i      = 1'b0;
    ex_br_instr_addr_i = '0;
    ex_br_taken_i      = 1'b0;
    lookup_req_i       = 1'b0;
    lookup_index_i     = '0;
    tbl_yout_i         = '0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic push(input logic [9:0] idx, input logic taken);
    ex_br_valid_i      = 1'b1;
    ex_br_instr_addr_i = {20'hABCDE, idx, 2'b11};
    ex_br_taken_i      = taken;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_n;
    int wr_n;
    int req_n;
    logic tk [6];

    vecs[0] = '{1'b1, -16'sd3,     10'd5,   1'b1};
    vecs[1] = '{1'b1, 16'sd40,     10'd6,   1'b0};
    vecs[2] = '{1'b0, -16'sd32768, 10'd7,   1'b0};
    vecs[3] = '{1'b0, 16'sd5,      10'd100, 1'b1};
    vecs[4] = '{1'b1, 16'sd29,     10'd1023, 1'b1};
    vecs[5] = '{1'b1, 16'sd30,     10'd0,   1'b0};
    vecs[6] = '{1'b0, -16'sd30,    10'd9,   1'b0};
    vecs[7] = '{1'b0, -16'sd29,    10'd10,  1'b1};
    vecs[8] = '{1'b0, 16'sd32767,  10'd11,  1'b1};

    // reset values
    do_reset();
    #1;
    chk("rst_ghr", 32'(ghr_o), 32'h0);
    chk("rst_drop", 32'(drop_cnt_o), 32'h0);
    chk("rst_train", 32'(train_cnt_o), 32'h0);
    chk("rst_req", 32'(tbl_req_o), 32'h0);
    lookup_req_i   = 1'b1;
    lookup_index_i = 10'h155;
    #1;
    chk("rst_gnt1", 32'(lookup_gnt_o), 32'h1);
    chk("rst_lk_req", 32'(tbl_req_o), 32'h1);
    chk("rst_lk_we", 32'(tbl_we_o), 32'h0);
    chk("rst_lk_idx", 32'(tbl_index_o), 32'h155);
    lookup_req_i = 1'b0;
    #1;
    chk("rst_gnt0", 32'(lookup_gnt_o), 32'h0);

    // EVAL decision table
    for (int v = 0; v < NV; v++) begin
      do_reset();
      push(vecs[v].idx, vecs[v].taken);
      tick();
      ex_br_valid_i = 1'b0;
      #1;
      chk("vec_ghr", 32'(ghr_o), 32'(vecs[v].taken));
      chk("vec_n1_req", 32'(tbl_req_o), 32'h0);
      tick();
      #1;
      chk("vec_rd_req", 32'(tbl_req_o), 32'h1);
      chk("vec_rd_we", 32'(tbl_we_o), 32'h0);
      chk("vec_rd_idx", 32'(tbl_index_o), 32'(vecs[v].idx));
      chk("vec_rd_ghr", 32'(tbl_ghr_o), 32'h0);
      tick();
      tbl_yout_i = vecs[v].yout;
      #1;
      chk("vec_eval_req", 32'(tbl_req_o), 32'h0);
      tick();
      tbl_yout_i = '0;
      #1;
      chk("vec_wr_req", 32'(tbl_req_o), 32'(vecs[v].exp_wr));
      chk("vec_wr_we", 32'(tbl_we_o), 32'(vecs[v].exp_wr));
      if (vecs[v].exp_wr) begin
        chk("vec_wr_taken", 32'(tbl_taken_o), 32'(vecs[v].taken));
        chk("vec_wr_idx", 32'(tbl_index_o), 32'(vecs[v].idx));
      end
      tick();
      #1;
      chk("vec_train_cnt", 32'(train_cnt_o), 32'(STATS * int'(vecs[v].exp_wr)));
      chk("vec_after_req", 32'(tbl_req_o), 32'h0);
    end

    // starvation: lookups hold the port for exactly StarveLimit cycles
    do_reset();
    lookup_req_i   = 1'b1;
    lookup_index_i = 10'h3FF;
    push(10'd3, 1'b1);
    tick();
    ex_br_valid_i = 1'b0;
    #1;
    chk("stv_gnt_idle", 32'(lookup_gnt_o), 32'h1);
    tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("stv_gnt_blocked", 32'(lookup_gnt_o), 32'h1);
      chk("stv_idx_blocked", 32'(tbl_index_o), 32'h3FF);
      tick();
    end
    #1;
    chk("stv_gnt_forced", 32'(lookup_gnt_o), 32'h0);
    chk("stv_rd_req", 32'(tbl_req_o), 32'h1);
    chk("stv_rd_we", 32'(tbl_we_o), 32'h0);
    chk("stv_rd_idx", 32'(tbl_index_o), 32'h3);
    tick();
    tbl_yout_i = 16'sd100;
    #1;
    chk("stv_gnt_eval", 32'(lookup_gnt_o), 32'h1);
    tick();
    tbl_yout_i   = '0;
    lookup_req_i = 1'b0;

    // overflow: six pushes into a four-deep queue with the port blocked
    do_reset();
    lookup_req_i = 1'b1;
    tk = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      push(10'(10 + i), tk[i]);
      tick();
    end
    ex_br_valid_i = 1'b0;
    #1;
    chk("ovf_ghr", 32'(ghr_o), 32'h02D);
    chk("ovf_drop", 32'(drop_cnt_o), 32'(STATS * 2));
    lookup_req_i = 1'b0;
    tbl_yout_i   = '0;
    #1;
    rd_n = 0;
    wr_n = 0;
    for (int c = 0; c < 30; c++) begin
      if (tbl_req_o && !tbl_we_o) begin
        if (rd_n < 4) chk("ovf_rd_order", 32'(tbl_index_o), 32'(10 + rd_n));
        rd_n++;
      end
      if (tbl_req_o && tbl_we_o) wr_n++;
      tick();
    end
    chk("ovf_reads", 32'(rd_n), 32'd4);
    chk("ovf_writes", 32'(wr_n), 32'd4);
    chk("ovf_train_cnt", 32'(train_cnt_o), 32'(STATS * 4));

    // reset while a training write is pending
    do_reset();
    push(10'd20, 1'b1);
    tick();
    ex_br_valid_i = 1'b0;
    tick();
    tick();
    tbl_yout_i = -16'sd3;
    tick();
    tbl_yout_i = '0;
    #1;
    chk("rmid_in_write", 32'(tbl_we_o), 32'h1);
    rst_i = 1'b1;
    #1;
    chk("rmid_rst_req", 32'(tbl_req_o), 32'h0);
    chk("rmid_rst_we", 32'(tbl_we_o), 32'h0);
    tick();
    rst_i = 1'b0;
    #1;
    chk("rmid_ghr", 32'(ghr_o), 32'h0);
    chk("rmid_train_cnt", 32'(train_cnt_o), 32'h0);
    req_n = 0;
    for (int c = 0; c < 6; c++) begin
      if (tbl_req_o) req_n++;
      tick();
    end
    chk("rmid_no_access", 32'(req_n), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
